// File: rtl/axi4l_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4l_pkg
//  Description : Shared types and constants for the AXI4-Lite initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4l_pkg;

    // AXI4-Lite BRESP/RRESP encodings
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Initiator control states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RESP    = 3'd5,
        ST_FAULT   = 3'd6
    } master_state_t;

    // Unprivileged, secure, data access
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage : axi4l_pkg
`default_nettype wire

// File: rtl/axi4l_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4l_master_if
//  Description : AXI4-Lite bus bundle with initiator and target views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi4l_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );

endinterface : axi4l_master_if
`default_nettype wire

// File: rtl/axi4l_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi4l_master
//  Description : Single-outstanding AXI4-Lite initiator. Turns valid/ready
//                commands into AXI reads/writes and returns one response
//                per command. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4l_master
    import axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic                    clk,
    input  wire logic                    rstn,

    input  wire logic                    cmd_valid,
    output logic                         cmd_ready,
    input  wire logic                    cmd_write,
    input  wire logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  wire logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  wire logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                         rsp_valid,
    input  wire logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic                         rsp_timeout,

    axi4l_master_if.master               axi
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    // Counter only has to reach TIMEOUT_CYCLES-1
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $error("axi4l_master: DATA_WIDTH must be 32 or 64");
    end

    master_state_t          state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   bready_q, bready_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]  wstrb_q, wstrb_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [1:0]             rsp_resp_q, rsp_resp_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic [CNT_WIDTH-1:0]   wd_cnt_q, wd_cnt_d;

    logic                   aw_hs, w_hs, wd_expired;

    assign aw_hs      = awvalid_q && axi.awready;
    assign w_hs       = wvalid_q && axi.wready;
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);

    // Next-state and next-output computation; every register holds by default
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_cnt_d      = wd_cnt_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end

            // AW and W retire independently; no watchdog since VALID cannot be withdrawn
            ST_WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    wd_cnt_d = '0;
                    state_d  = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (axi.bvalid && bready_q) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = axi.bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (wd_expired) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = SLVERR;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_WIDTH'(1);
                end
            end

            ST_RD_REQ: begin
                if (arvalid_q && axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    wd_cnt_d  = '0;
                    state_d   = ST_RD_RESP;
                end
            end

            ST_RD_RESP: begin
                if (axi.rvalid && rready_q) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = axi.rresp;
                    rsp_rdata_d   = axi.rdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (wd_expired) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = SLVERR;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_WIDTH'(1);
                end
            end

            // Payload held stable until consumed; a timed-out transaction locks the port
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_timeout_q) begin
                        state_d = ST_FAULT;
                    end else begin
                        cmd_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            // A late B/R beat could still arrive; refuse new work until reset
            ST_FAULT: begin
                cmd_ready_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops with asynchronous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

    assign axi.awaddr  = addr_q;
    assign axi.awprot  = AXI_PROT_DEFAULT;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = AXI_PROT_DEFAULT;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule : axi4l_master
`default_nettype wire

// File: tb/tb_axi4l_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4l_master
//  Description : Directed self-checking bench for axi4l_master.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4l_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int errors = 0;
    int checks = 0;

    axi4l_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi4l_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .axi         (axi)
    );

    always #5 clk = ~clk;

    // Absolute time bound in case the design stalls
    initial begin
        #200000;
        $display("FAIL global_timeout: observed=stalled expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; stimulus and sampling happen 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    initial begin
        rstn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0;  axi.bresp = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid = 1'b0;  axi.rdata = '0; axi.rresp = 2'b00;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_rsp_payload", {rsp_timeout, rsp_resp, rsp_rdata}, 0);
        rstn = 1'b1;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // ---------------- zero-wait write ----------------
        axi.awready = 1'b1; axi.wready = 1'b1;
        issue(1'b1, 32'h0000_0004, 32'hA5A5_00FF, 4'hF);
        tick();                                  // accepted at N
        cmd_valid = 1'b0;
        chk("w0_awvalid", axi.awvalid, 1);
        chk("w0_wvalid", axi.wvalid, 1);
        chk("w0_awaddr", axi.awaddr, 32'h0000_0004);
        chk("w0_wdata", axi.wdata, 32'hA5A5_00FF);
        chk("w0_wstrb", axi.wstrb, 4'hF);
        chk("w0_awprot", axi.awprot, 3'b000);
        chk("w0_cmd_ready", cmd_ready, 0);
        tick();                                  // AW/W handshake at N+1
        chk("w0_awvalid_drop", axi.awvalid, 0);
        chk("w0_wvalid_drop", axi.wvalid, 0);
        chk("w0_bready", axi.bready, 1);
        chk("w0_rsp_not_yet", rsp_valid, 0);
        axi.bvalid = 1'b1; axi.bresp = 2'b00;
        tick();                                  // B handshake at N+2
        axi.bvalid = 1'b0;
        chk("w0_rsp_valid", rsp_valid, 1);
        chk("w0_rsp_resp", rsp_resp, 2'b00);
        chk("w0_rsp_rdata", rsp_rdata, 0);
        chk("w0_rsp_timeout", rsp_timeout, 0);
        chk("w0_bready_drop", axi.bready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w0_rsp_done", rsp_valid, 0);
        chk("w0_next_cmd_ready", cmd_ready, 1);

        // ---------------- delayed awready, SLVERR, slow rsp_ready ----------------
        axi.awready = 1'b0; axi.wready = 1'b1;
        issue(1'b1, 32'h0000_0008, 32'h0000_1234, 4'h3);
        tick();
        cmd_valid = 1'b0;
        chk("w1_c1_awvalid", axi.awvalid, 1);
        chk("w1_c1_wvalid", axi.wvalid, 1);
        axi.bvalid = 1'b1; axi.bresp = 2'b10;   // early B must be ignored
        tick();
        chk("w1_c2_awvalid", axi.awvalid, 1);
        chk("w1_c2_wvalid", axi.wvalid, 0);
        chk("w1_c2_bready", axi.bready, 0);
        tick();
        chk("w1_c3_awvalid", axi.awvalid, 1);
        chk("w1_c3_bready", axi.bready, 0);
        chk("w1_c3_rsp_valid", rsp_valid, 0);
        axi.awready = 1'b1;
        tick();
        chk("w1_c4_awvalid", axi.awvalid, 0);
        chk("w1_c4_bready", axi.bready, 1);
        tick();
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            chk("w1_hold_rsp_valid", rsp_valid, 1);
            chk("w1_hold_payload", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, 2'b10, 32'h0});
            chk("w1_hold_cmd_ready", cmd_ready, 0);
            tick();
        end
        chk("w1_still_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w1_rsp_done", rsp_valid, 0);
        chk("w1_cmd_ready", cmd_ready, 1);

        // ---------------- read with DECERR ----------------
        axi.arready = 1'b1;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        chk("r0_arvalid", axi.arvalid, 1);
        chk("r0_araddr", axi.araddr, 32'h0000_0010);
        chk("r0_arprot", axi.arprot, 3'b000);
        chk("r0_no_awvalid", axi.awvalid, 0);
        tick();
        chk("r0_arvalid_drop", axi.arvalid, 0);
        chk("r0_rready", axi.rready, 1);
        axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF; axi.rresp = 2'b11;
        tick();
        axi.rvalid = 1'b0;
        chk("r0_rsp_valid", rsp_valid, 1);
        chk("r0_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("r0_rsp_resp", rsp_resp, 2'b11);
        chk("r0_rsp_timeout", rsp_timeout, 0);
        chk("r0_rready_drop", axi.rready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("r0_cmd_ready", cmd_ready, 1);

        // ---------------- write response timeout ----------------
        axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0;
        issue(1'b1, 32'h0000_0020, 32'h5555_AAAA, 4'hF);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("to_bready_high", axi.bready, 1);
            tick();
        end
        chk("to_bready_drop", axi.bready, 0);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_resp", rsp_resp, 2'b10);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("to_rsp_done", rsp_valid, 0);
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            chk("fault_cmd_ready", cmd_ready, 0);
            chk("fault_arvalid", axi.arvalid, 0);
            tick();
        end
        cmd_valid = 1'b0;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        tick();
        chk("fault_cleared_cmd_ready", cmd_ready, 1);

        // ---------------- reset mid-write, then fresh read ----------------
        axi.awready = 1'b0; axi.wready = 1'b0;
        issue(1'b1, 32'h0000_0024, 32'h0123_4567, 4'hF);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_awvalid_before", axi.awvalid, 1);
        rstn = 1'b0;
        #1;
        chk("mid_awvalid_async", axi.awvalid, 0);
        chk("mid_wvalid_async", axi.wvalid, 0);
        chk("mid_cmd_ready_async", cmd_ready, 0);
        #2;
        rstn = 1'b1;
        tick();
        chk("mid_cmd_ready_first_edge", cmd_ready, 1);
        axi.arready = 1'b1;
        issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        chk("r1_arvalid", axi.arvalid, 1);
        chk("r1_araddr", axi.araddr, 32'h0000_0030);
        tick();
        chk("r1_rready", axi.rready, 1);
        axi.rvalid = 1'b1; axi.rdata = 32'h0BAD_F00D; axi.rresp = 2'b00;
        tick();
        axi.rvalid = 1'b0;
        chk("r1_rsp_valid", rsp_valid, 1);
        chk("r1_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        chk("r1_rsp_resp", rsp_resp, 2'b00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("r1_cmd_ready", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axi4l_master
`default_nettype wire
